lift_motion_fsm: RTL and testbench
==================================

# lift_motion_fsm

Car-motion and door sequencer for the lift controller, downstream of the clock-divider stage. It consumes the divider's `clk_1s` square wave as a sampled signal, not as a clock, and turns it into a one-cycle seconds tick in the `clk_100MHz` domain. It latches floor-call buttons, runs a direction-preserving (SCAN) service order, and times floor-to-floor travel and door dwell in whole seconds. Its outputs drive the floor display and the motor/door indicators.

## Interface
- `NUM_FLOORS`, default 4: number of floors, numbered 0..NUM_FLOORS-1.
- `FLOOR_W`, default 2: floor index width; must be ≥ clog2(NUM_FLOORS).
- `TRAVEL_S`, default 2: seconds per one-floor move; ≥ 1.
- `DOOR_S`, default 3: door dwell in seconds; ≥ 1.

Ports:
- `clk_100MHz` input 1: the single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `clk_1s` input 1: 1 s square wave from the divider, asynchronous to this logic.
- `req_btn` input NUM_FLOORS: call buttons, level, one bit per floor.
- `floor` output FLOOR_W: current car floor.
- `dir_up` output 1: current/last travel direction; 1 = up.
- `moving` output 1: high in UP or DOWN.
- `door_open` output 1: high in DOOR.
- `req_pending` output NUM_FLOORS: latched, unserved calls.

## Operation
- Tick path:
  - `clk_1s` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - `tick` = sync2 & ~sync3, a one-cycle pulse per `clk_1s` rising edge.
- Request latch: every cycle, `req_pending <= (req_pending | req_btn) & ~clr`.
  - `clr` is a one-hot bit for `floor`, asserted whenever the FSM enters or re-arms DOOR.
  - When set and clear hit the same bit in the same cycle, clear wins.
- States: IDLE, DOOR, UP, DOWN. A tick counter `sec_cnt` resets to 0 on every state entry.
- IDLE:
  - If `pending[floor]`: go to DOOR and clear that bit.
  - Else, if a call exists above and (`dir_up`, or no call below): set `dir_up`=1, go to UP.
  - Else, if a call exists below: set `dir_up`=0, go to DOWN.
  - Else stay in IDLE.
- UP / DOWN:
  - Each tick increments `sec_cnt`.
  - On the tick that makes `sec_cnt` == TRAVEL_S, `floor` steps ±1 and an arrival decision is made in the same cycle against the new floor:
    - pending at the new floor: go to DOOR and clear the bit;
    - else a call further in the same direction: stay in the state with `sec_cnt`=0;
    - else go to IDLE.
  - UP is entered only if a call exists above, so `floor` never passes NUM_FLOORS-1. DOWN likewise never passes 0.
- DOOR:
  - Each tick increments `sec_cnt`. On the tick that makes `sec_cnt` == DOOR_S, go to IDLE.
  - A new call for the current floor during DOOR clears immediately and restarts `sec_cnt` at 0 (door held).
- A call for the floor being departed, raised while moving, stays pending and is served on a later pass.
- Reset (async, `rst_n`=0), effective immediately, including mid-move or mid-door:
  - state IDLE, `floor`=0, `dir_up`=1, `moving`=0, `door_open`=0, `req_pending`=0.
  - sync flops 0, `sec_cnt`=0.

## Timing
- A `clk_1s` rising edge yields `tick` high in the 3rd clock after the edge is first sampled. Tick-to-tick spacing equals the `clk_1s` period.
- Outputs are registered; they change on the clock edge of the state transition.
- A button bit appears in `req_pending` 1 cycle after it is sampled high.
- IDLE→DOOR or IDLE→UP/DOWN occurs 1 cycle after the relevant pending bit is visible.
- Dwell/travel ends on the Nth tick after state entry (N = DOOR_S or TRAVEL_S). Wall time is therefore between N−1 and N seconds, because entry is mid-second.
- `sec_cnt` width is clog2(max(TRAVEL_S, DOOR_S)+1). The counter never wraps, because its compare value is reached first.

## Structure
- Shared package `lift_pkg` holds:
  - the state encoding (IDLE=0, DOOR=1, UP=2, DOWN=3);
  - defaults for NUM_FLOORS, FLOOR_W, TRAVEL_S, DOOR_S;
  - the `clog2` helper.
- Sub-module `tick_sync`: synchronizer + rising-edge detector. Ports `clk_100MHz`, `rst_n`, `clk_1s` → `tick`. It is reused by other stages that consume divider outputs.
- Top: request latch, above/below reduction logic, FSM, `sec_cnt`.

## Test plan
Simulate with TRAVEL_S=2, DOOR_S=3 and `clk_1s` period shortened to 20 cycles.
- Reset then idle: hold `rst_n`=0 for 5 cycles, then release with no buttons → all outputs 0 except `dir_up`=1; state stays IDLE across 10 ticks.
- Single up call: pulse `req_btn[2]` at floor 0 →
  - `moving`=1, `dir_up`=1;
  - `floor` 0→1→2, each step on the 2nd tick;
  - `door_open`=1 for 3 ticks, `req_pending[2]` cleared on arrival, then IDLE.
- SCAN order: car moving up at floor 1, press 3 and then 0 → serves 3 first, then reverses to `dir_up`=0 and serves 0; `req_pending` ends at 0.
- Door hold: during DOOR at floor 1, press `req_btn[1]` on the 2nd tick → `sec_cnt` restarts; door closes 3 ticks after the re-press, not the original 3.
- Mid-move reset: assert `rst_n` between floors 1 and 2 → `floor`=0, `moving`=0, `req_pending`=0 asynchronously, before the next clock edge.
- Same-cycle set/clear: hold `req_btn[2]` high through arrival at floor 2 → bit stays cleared while in DOOR, and the door timer re-arms each cycle the button is held.

Source files
------------

// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared state encoding, parameter defaults and helpers for the lift stages
package lift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOOR = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } lift_state_t;

    localparam int DEF_NUM_FLOORS = 4;
    localparam int DEF_FLOOR_W    = 2;
    localparam int DEF_TRAVEL_S   = 2;
    localparam int DEF_DOOR_S     = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_sync.sv
// rtl/tick_sync.sv - synchronizes a divider square wave and emits a one-cycle pulse per rising edge
module tick_sync (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clk_1s,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk_1s;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

endmodule

// File: rtl/lift_motion_fsm.sv
// rtl/lift_motion_fsm.sv - call latch, SCAN service order, travel and door timing for the lift car
module lift_motion_fsm
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W,
    parameter int TRAVEL_S   = DEF_TRAVEL_S,
    parameter int DOOR_S     = DEF_DOOR_S
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic                  clk_1s,
    input  logic [NUM_FLOORS-1:0] req_btn,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] req_pending
);

    localparam int CNT_MAX = (TRAVEL_S > DOOR_S) ? TRAVEL_S : DOOR_S;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRAVEL_CNT = CNT_W'(TRAVEL_S);
    localparam logic [CNT_W-1:0] DOOR_CNT   = CNT_W'(DOOR_S);

    lift_state_t           state;
    lift_state_t           state_nxt;
    logic [FLOOR_W-1:0]    floor_nxt;
    logic [FLOOR_W-1:0]    floor_step;
    logic                  dir_up_nxt;
    logic [CNT_W-1:0]      sec_cnt;
    logic [CNT_W-1:0]      sec_cnt_nxt;
    logic [CNT_W-1:0]      sec_inc;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] floor_hot;
    logic [NUM_FLOORS-1:0] step_hot;
    logic                  call_above;
    logic                  call_below;
    logic                  tick;

    function automatic logic [NUM_FLOORS-1:0] one_hot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0]    f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && p[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    tick_sync u_tick_sync (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clk_1s     (clk_1s),
        .tick       (tick)
    );

    assign floor_hot  = one_hot(floor);
    assign floor_step = (state == ST_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    assign step_hot   = one_hot(floor_step);
    assign sec_inc    = sec_cnt + CNT_W'(1);
    assign call_above = any_above(req_pending, floor);
    assign call_below = any_below(req_pending, floor);

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            floor       <= '0;
            dir_up      <= 1'b1;
            sec_cnt     <= '0;
            req_pending <= '0;
        end else begin
            state       <= state_nxt;
            floor       <= floor_nxt;
            dir_up      <= dir_up_nxt;
            sec_cnt     <= sec_cnt_nxt;
            req_pending <= (req_pending | req_btn) & ~clr;
        end
    end

    always_comb begin
        state_nxt   = state;
        floor_nxt   = floor;
        dir_up_nxt  = dir_up;
        sec_cnt_nxt = sec_cnt;
        clr         = '0;
        case (state)
            ST_IDLE: begin
                if (|(req_pending & floor_hot)) begin
                    state_nxt   = ST_DOOR;
                    clr         = floor_hot;
                    sec_cnt_nxt = '0;
                end else if (call_above && (dir_up || !call_below)) begin
                    state_nxt   = ST_UP;
                    dir_up_nxt  = 1'b1;
                    sec_cnt_nxt = '0;
                end else if (call_below) begin
                    state_nxt   = ST_DOWN;
                    dir_up_nxt  = 1'b0;
                    sec_cnt_nxt = '0;
                end
            end
            ST_UP, ST_DOWN: begin
                if (tick) begin
                    if (sec_inc == TRAVEL_CNT) begin
                        // Arrival is judged against the floor being stepped onto.
                        floor_nxt   = floor_step;
                        sec_cnt_nxt = '0;
                        if (|(req_pending & step_hot)) begin
                            state_nxt = ST_DOOR;
                            clr       = step_hot;
                        end else if ((state == ST_UP) ? any_above(req_pending, floor_step)
                                                      : any_below(req_pending, floor_step)) begin
                            state_nxt = state;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        sec_cnt_nxt = sec_inc;
                    end
                end
            end
            ST_DOOR: begin
                // A fresh call at this floor holds the door and never reaches the pending set.
                if (|((req_pending | req_btn) & floor_hot)) begin
                    clr         = floor_hot;
                    sec_cnt_nxt = '0;
                end else if (tick) begin
                    if (sec_inc == DOOR_CNT) begin
                        state_nxt   = ST_IDLE;
                        sec_cnt_nxt = '0;
                    end else begin
                        sec_cnt_nxt = sec_inc;
                    end
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                sec_cnt_nxt = '0;
            end
        endcase
    end

    assign moving    = (state == ST_UP) || (state == ST_DOWN);
    assign door_open = (state == ST_DOOR);

endmodule

// File: tb/tb_lift_motion_fsm.sv
// tb/tb_lift_motion_fsm.sv - directed self-checking bench for lift_motion_fsm
module tb_lift_motion_fsm;

    logic       clk_100MHz;
    logic       rst_n;
    logic       clk_1s;
    logic [3:0] req_btn;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [3:0] req_pending;

    int total = 0;
    int bad   = 0;

    lift_motion_fsm #(
        .NUM_FLOORS (4),
        .FLOOR_W    (2),
        .TRAVEL_S   (2),
        .DOOR_S     (3)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .clk_1s      (clk_1s),
        .req_btn     (req_btn),
        .floor       (floor),
        .dir_up      (dir_up),
        .moving      (moving),
        .door_open   (door_open),
        .req_pending (req_pending)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        clk_1s = 1'b0;
        #2;
        forever #100 clk_1s = ~clk_1s;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk_1s);
        repeat (4) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic wait_sig(input bit sel_moving, input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (((sel_moving ? moving : door_open) !== val) && n < budget) begin
            @(posedge clk_100MHz);
            #1;
            n++;
        end
        chk(tag, 32'(sel_moving ? moving : door_open), 32'(val));
    endtask

    task automatic press(input logic [3:0] btn);
        req_btn = btn;
        @(posedge clk_100MHz);
        #1;
        req_btn = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_btn = '0;

        // reset then idle
        repeat (5) @(posedge clk_100MHz);
        #1;
        chk("rst_floor", 32'(floor), 0);
        chk("rst_dir", 32'(dir_up), 1);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_door", 32'(door_open), 0);
        chk("rst_pend", 32'(req_pending), 0);
        rst_n = 1'b1;
        wait_ticks(10);
        chk("idle_floor", 32'(floor), 0);
        chk("idle_moving", 32'(moving), 0);
        chk("idle_door", 32'(door_open), 0);
        chk("idle_dir", 32'(dir_up), 1);

        // single up call to floor 2
        wait_ticks(1);
        req_btn = 4'b0100;
        @(posedge clk_100MHz);
        #1;
        chk("up_pend_set", 32'(req_pending), 4'b0100);
        chk("up_not_yet", 32'(moving), 0);
        req_btn = '0;
        @(posedge clk_100MHz);
        #1;
        chk("up_moving", 32'(moving), 1);
        chk("up_dir", 32'(dir_up), 1);
        chk("up_floor0", 32'(floor), 0);
        wait_ticks(1);
        chk("up_t1_floor", 32'(floor), 0);
        wait_ticks(1);
        chk("up_t2_floor", 32'(floor), 1);
        chk("up_t2_moving", 32'(moving), 1);
        wait_ticks(1);
        chk("up_t3_floor", 32'(floor), 1);
        wait_ticks(1);
        chk("arr_floor", 32'(floor), 2);
        chk("arr_door", 32'(door_open), 1);
        chk("arr_moving", 32'(moving), 0);
        chk("arr_pend", 32'(req_pending), 0);
        wait_ticks(2);
        chk("door_t2", 32'(door_open), 1);
        wait_ticks(1);
        chk("door_t3", 32'(door_open), 0);
        chk("door_t3_mov", 32'(moving), 0);
        chk("door_t3_floor", 32'(floor), 2);

        // SCAN: moving up at floor 1, press 3 then 0
        do_reset();
        wait_ticks(1);
        press(4'b0100);
        wait_sig(1'b1, 1'b1, 50, "scan_start");
        wait_ticks(2);
        chk("scan_at1", 32'(floor), 1);
        press(4'b1000);
        press(4'b0001);
        chk("scan_pend", 32'(req_pending), 4'b1101);
        wait_sig(1'b0, 1'b1, 2000, "scan_door2");
        chk("scan_floor2", 32'(floor), 2);
        wait_sig(1'b0, 1'b0, 2000, "scan_close2");
        wait_sig(1'b1, 1'b1, 100, "scan_mv3");
        chk("scan_dir_up", 32'(dir_up), 1);
        wait_sig(1'b0, 1'b1, 2000, "scan_door3");
        chk("scan_floor3", 32'(floor), 3);
        wait_sig(1'b0, 1'b0, 2000, "scan_close3");
        wait_sig(1'b1, 1'b1, 100, "scan_mv0");
        chk("scan_dir_dn", 32'(dir_up), 0);
        wait_sig(1'b0, 1'b1, 4000, "scan_door0");
        chk("scan_floor0", 32'(floor), 0);
        chk("scan_pend_end", 32'(req_pending), 0);

        // door hold at floor 1
        wait_sig(1'b0, 1'b0, 2000, "hold_idle");
        press(4'b0010);
        wait_sig(1'b0, 1'b1, 2000, "hold_door");
        chk("hold_floor", 32'(floor), 1);
        wait_ticks(2);
        chk("hold_pre", 32'(door_open), 1);
        press(4'b0010);
        chk("hold_pend", 32'(req_pending), 0);
        wait_ticks(1);
        chk("hold_r1", 32'(door_open), 1);
        wait_ticks(1);
        chk("hold_orig", 32'(door_open), 1);
        wait_ticks(1);
        chk("hold_close", 32'(door_open), 0);

        // reset while moving from floor 1 toward 2
        press(4'b1000);
        wait_sig(1'b1, 1'b1, 50, "mr_start");
        wait_ticks(1);
        chk("mr_pre_floor", 32'(floor), 1);
        chk("mr_pre_pend", 32'(req_pending), 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_floor", 32'(floor), 0);
        chk("mr_moving", 32'(moving), 0);
        chk("mr_pend", 32'(req_pending), 0);
        chk("mr_door", 32'(door_open), 0);
        @(posedge clk_100MHz);
        #1;
        rst_n = 1'b1;

        // button held through arrival at floor 2
        wait_ticks(1);
        req_btn = 4'b0100;
        wait_sig(1'b0, 1'b1, 2000, "hd_door");
        chk("hd_floor", 32'(floor), 2);
        chk("hd_pend0", 32'(req_pending), 0);
        wait_ticks(4);
        chk("hd_held", 32'(door_open), 1);
        chk("hd_pend1", 32'(req_pending), 0);
        req_btn = '0;
        wait_ticks(2);
        chk("hd_rel2", 32'(door_open), 1);
        wait_ticks(1);
        chk("hd_close", 32'(door_open), 0);
        chk("hd_pend_end", 32'(req_pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
